// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
// State list, ALU operation codes, opcode/funct values and datapath select codes.
package mc_pkg;

    typedef enum logic [3:0] {
        StRst,
        StFetch,
        StDecode,
        StMemAddr,
        StMemRead,
        StWbMem,
        StMemWrite,
        StRExec,
        StRWb,
        StBeq,
        StJump,
        StAddiExec,
        StAddiWb,
        StIllegal,
        StFault
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0101;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Per-state control word; fetch and done_on_ack are qualified by mem_ack at the output.
    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       fetch;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctr;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       done;
        logic       done_on_ack;
        logic       illegal;
        logic       fault;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle FSM (master) and the datapath/memory (slave).
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       Op;
    logic [5:0]       Funct;
    logic             mem_ack;
    logic             mem_req;
    logic             MemRead;
    logic             MemWrite;
    logic             IorD;
    logic             IRWrite;
    logic             PCWrite;
    logic             PCWriteCond;
    logic [1:0]       PCSource;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [3:0]       ALUCtr;
    logic             RegWrite;
    logic             RegDst;
    logic             MemtoReg;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;
    logic             illegal_op;
    logic             fault;

    modport master (
        input  Op, Funct, mem_ack,
        output mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
               ALUSrcA, ALUSrcB, ALUCtr, RegWrite, RegDst, MemtoReg, instr_done,
               instr_count, illegal_op, fault
    );

    modport slave (
        output Op, Funct, mem_ack,
        input  mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
               ALUSrcA, ALUSrcB, ALUCtr, RegWrite, RegDst, MemtoReg, instr_done,
               instr_count, illegal_op, fault
    );
endinterface

// File: rtl/multicycle_ctrl_alu_funct_dec.sv
// R-type Funct field to ALU operation decoder; valid_o low for unsupported functions.
module alu_funct_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctr_o,
    output logic       valid_o
);

    always_comb begin
        alu_ctr_o = ALU_ADD;
        valid_o   = 1'b1;
        case (funct_i)
            FN_ADD:  alu_ctr_o = ALU_ADD;
            FN_SUB:  alu_ctr_o = ALU_SUB;
            FN_AND:  alu_ctr_o = ALU_AND;
            FN_OR:   alu_ctr_o = ALU_OR;
            FN_SLT:  alu_ctr_o = ALU_SLT;
            default: valid_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath: sequencing, memory handshake,
// retired-instruction counting and sticky memory-timeout fault.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input logic                clk,
    input logic                rst_n,
    multicycle_ctrl_if.master  bus
);

    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    ctrl_t              ctl_q, ctl_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   count_q;
    logic [3:0]         fn_ctr;
    logic               fn_valid;
    logic               timeout_hit;
    logic               done;

    alu_funct_dec u_funct_dec (
        .funct_i   (bus.Funct),
        .alu_ctr_o (fn_ctr),
        .valid_o   (fn_valid)
    );

    // Reaching the limit with no ack moves to FAULT; an ack in that same cycle still wins.
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == WaitW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            StRst: state_d = StFetch;
            StFetch, StMemRead, StMemWrite: begin
                if (bus.mem_ack) begin
                    if (state_q == StFetch)        state_d = StDecode;
                    else if (state_q == StMemRead) state_d = StWbMem;
                    else                           state_d = StFetch;
                end else if (timeout_hit) begin
                    state_d = StFault;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDecode: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_d = StMemAddr;
                    OP_RTYPE:     state_d = StRExec;
                    OP_BEQ:       state_d = StBeq;
                    OP_J:         state_d = StJump;
                    OP_ADDI:      state_d = StAddiExec;
                    default:      state_d = StIllegal;
                endcase
            end
            StMemAddr:  state_d = (bus.Op == OP_SW) ? StMemWrite : StMemRead;
            StRExec:    state_d = fn_valid ? StRWb : StIllegal;
            StAddiExec: state_d = StAddiWb;
            StFault:    state_d = StFault;
            default:    state_d = StFetch;
        endcase
    end

    // Control word for the state being entered, so outputs come straight from flops.
    always_comb begin
        ctl_d = '0;
        case (state_d)
            StFetch: begin
                ctl_d.mem_req   = 1'b1;
                ctl_d.mem_read  = 1'b1;
                ctl_d.fetch     = 1'b1;
                ctl_d.alu_src_b = SRCB_FOUR;
                ctl_d.alu_ctr   = ALU_ADD;
                ctl_d.pc_source = PCSRC_ALU;
            end
            StDecode: begin
                ctl_d.alu_src_b = SRCB_IMM_SH2;
                ctl_d.alu_ctr   = ALU_ADD;
            end
            StMemAddr, StAddiExec: begin
                ctl_d.alu_src_a = 1'b1;
                ctl_d.alu_src_b = SRCB_IMM;
                ctl_d.alu_ctr   = ALU_ADD;
            end
            StMemRead: begin
                ctl_d.mem_req  = 1'b1;
                ctl_d.mem_read = 1'b1;
                ctl_d.iord     = 1'b1;
            end
            StWbMem: begin
                ctl_d.mem_to_reg = 1'b1;
                ctl_d.reg_write  = 1'b1;
                ctl_d.done       = 1'b1;
            end
            StMemWrite: begin
                ctl_d.mem_req     = 1'b1;
                ctl_d.mem_write   = 1'b1;
                ctl_d.iord        = 1'b1;
                ctl_d.done_on_ack = 1'b1;
            end
            StRExec: begin
                ctl_d.alu_src_a = 1'b1;
                ctl_d.alu_src_b = SRCB_RT;
                ctl_d.alu_ctr   = fn_valid ? fn_ctr : ALU_ADD;
            end
            StRWb: begin
                ctl_d.reg_dst   = 1'b1;
                ctl_d.reg_write = 1'b1;
                ctl_d.done      = 1'b1;
            end
            StBeq: begin
                ctl_d.alu_src_a     = 1'b1;
                ctl_d.alu_src_b     = SRCB_RT;
                ctl_d.alu_ctr       = ALU_SUB;
                ctl_d.pc_write_cond = 1'b1;
                ctl_d.pc_source     = PCSRC_ALUOUT;
                ctl_d.done          = 1'b1;
            end
            StJump: begin
                ctl_d.pc_write  = 1'b1;
                ctl_d.pc_source = PCSRC_JUMP;
                ctl_d.done      = 1'b1;
            end
            StAddiWb: begin
                ctl_d.reg_write = 1'b1;
                ctl_d.done      = 1'b1;
            end
            StIllegal: ctl_d.illegal = 1'b1;
            StFault:   ctl_d.fault   = 1'b1;
            default:   ctl_d = '0;
        endcase
    end

    assign done = ctl_q.done | (ctl_q.done_on_ack & bus.mem_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRst;
            ctl_q   <= '0;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            wait_q  <= wait_d;
            if (done) count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.mem_req     = ctl_q.mem_req;
    assign bus.MemRead     = ctl_q.mem_read;
    assign bus.MemWrite    = ctl_q.mem_write;
    assign bus.IorD        = ctl_q.iord;
    assign bus.IRWrite     = ctl_q.fetch & bus.mem_ack;
    assign bus.PCWrite     = ctl_q.pc_write | (ctl_q.fetch & bus.mem_ack);
    assign bus.PCWriteCond = ctl_q.pc_write_cond;
    assign bus.PCSource    = ctl_q.pc_source;
    assign bus.ALUSrcA     = ctl_q.alu_src_a;
    assign bus.ALUSrcB     = ctl_q.alu_src_b;
    assign bus.ALUCtr      = ctl_q.alu_ctr;
    assign bus.RegWrite    = ctl_q.reg_write;
    assign bus.RegDst      = ctl_q.reg_dst;
    assign bus.MemtoReg    = ctl_q.mem_to_reg;
    assign bus.instr_done  = done;
    assign bus.instr_count = count_q;
    assign bus.illegal_op  = ctl_q.illegal;
    assign bus.fault       = ctl_q.fault;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus wait/timeout/reset sequences.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) bus ();

    multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [21:0] obs;
    assign obs = {bus.mem_req, bus.MemRead, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCWrite,
                  bus.PCWriteCond, bus.PCSource, bus.ALUSrcA, bus.ALUSrcB, bus.ALUCtr,
                  bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.instr_done, bus.illegal_op,
                  bus.fault};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [21:0] exp;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [21:0] pk(input logic mreq, rd, wr, iord, irw, pcw, pcwc,
                                       input logic [1:0] pcs, input logic sa,
                                       input logic [1:0] sb, input logic [3:0] alu,
                                       input logic rw, rdst, m2r, dn, il, ft);
        return {mreq, rd, wr, iord, irw, pcw, pcwc, pcs, sa, sb, alu, rw, rdst, m2r, dn, il, ft};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic row(input logic [5:0] op, input logic [5:0] fn, input logic [21:0] e,
                       input int cnt);
        vec_t v;
        v.op = op; v.fn = fn; v.exp = e; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [21:0] e_fetch, e_fetch_wait, e_dec, e_rwb, e_beq, e_maddr, e_mwr_ack, e_mwr_wait;
    logic [21:0] e_mrd_ack, e_wbmem, e_addiex, e_addiwb, e_jump, e_ill, e_fault;
    logic [21:0] e_radd, e_ror, e_rslt;
    int rd_cycles, done_cycle;
    logic m2r_at_done;

    initial begin
        e_fetch      = pk(1,1,0,0,1,1,0,2'b00,0,2'b01,4'b0010,0,0,0,0,0,0);
        e_fetch_wait = pk(1,1,0,0,0,0,0,2'b00,0,2'b01,4'b0010,0,0,0,0,0,0);
        e_dec        = pk(0,0,0,0,0,0,0,2'b00,0,2'b11,4'b0010,0,0,0,0,0,0);
        e_radd       = pk(0,0,0,0,0,0,0,2'b00,1,2'b00,4'b0010,0,0,0,0,0,0);
        e_ror        = pk(0,0,0,0,0,0,0,2'b00,1,2'b00,4'b0101,0,0,0,0,0,0);
        e_rslt       = pk(0,0,0,0,0,0,0,2'b00,1,2'b00,4'b0111,0,0,0,0,0,0);
        e_rwb        = pk(0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,1,0,1,0,0);
        e_beq        = pk(0,0,0,0,0,0,1,2'b01,1,2'b00,4'b0110,0,0,0,1,0,0);
        e_maddr      = pk(0,0,0,0,0,0,0,2'b00,1,2'b10,4'b0010,0,0,0,0,0,0);
        e_mwr_ack    = pk(1,0,1,1,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,1,0,0);
        e_mwr_wait   = pk(1,0,1,1,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0,0);
        e_mrd_ack    = pk(1,1,0,1,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0,0);
        e_wbmem      = pk(0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,0,1,1,0,0);
        e_addiex     = pk(0,0,0,0,0,0,0,2'b00,1,2'b10,4'b0010,0,0,0,0,0,0);
        e_addiwb     = pk(0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,0,0,1,0,0);
        e_jump       = pk(0,0,0,0,0,1,0,2'b10,0,2'b00,4'b0000,0,0,0,1,0,0);
        e_ill        = pk(0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,1,0);
        e_fault      = pk(0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0,1);

        // add, beq, or, slt, sw, addi, j, lw, bad Op, bad Funct; mem_ack held 1
        row(6'b000000, 6'b100000, e_fetch, 0);   row(6'b000000, 6'b100000, e_dec, 0);
        row(6'b000000, 6'b100000, e_radd, 0);    row(6'b000000, 6'b100000, e_rwb, 0);
        row(6'b000100, 6'b000000, e_fetch, 1);   row(6'b000100, 6'b000000, e_dec, 1);
        row(6'b000100, 6'b000000, e_beq, 1);
        row(6'b000000, 6'b100101, e_fetch, 2);   row(6'b000000, 6'b100101, e_dec, 2);
        row(6'b000000, 6'b100101, e_ror, 2);     row(6'b000000, 6'b100101, e_rwb, 2);
        row(6'b000000, 6'b101010, e_fetch, 3);   row(6'b000000, 6'b101010, e_dec, 3);
        row(6'b000000, 6'b101010, e_rslt, 3);    row(6'b000000, 6'b101010, e_rwb, 3);
        row(6'b101011, 6'b000000, e_fetch, 4);   row(6'b101011, 6'b000000, e_dec, 4);
        row(6'b101011, 6'b000000, e_maddr, 4);   row(6'b101011, 6'b000000, e_mwr_ack, 4);
        row(6'b001000, 6'b000000, e_fetch, 5);   row(6'b001000, 6'b000000, e_dec, 5);
        row(6'b001000, 6'b000000, e_addiex, 5);  row(6'b001000, 6'b000000, e_addiwb, 5);
        row(6'b000010, 6'b000000, e_fetch, 6);   row(6'b000010, 6'b000000, e_dec, 6);
        row(6'b000010, 6'b000000, e_jump, 6);
        row(6'b100011, 6'b000000, e_fetch, 7);   row(6'b100011, 6'b000000, e_dec, 7);
        row(6'b100011, 6'b000000, e_maddr, 7);   row(6'b100011, 6'b000000, e_mrd_ack, 7);
        row(6'b100011, 6'b000000, e_wbmem, 7);
        row(6'b111111, 6'b000000, e_fetch, 8);   row(6'b111111, 6'b000000, e_dec, 8);
        row(6'b111111, 6'b000000, e_ill, 8);
        row(6'b000000, 6'b000001, e_fetch, 8);   row(6'b000000, 6'b000001, e_dec, 8);
        row(6'b000000, 6'b000001, e_radd, 8);    row(6'b000000, 6'b000001, e_ill, 8);
        row(6'b000000, 6'b100000, e_fetch, 8);

        bus.Op = 6'b0;
        bus.Funct = 6'b0;
        bus.mem_ack = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_outputs", 32'(obs), 32'(0));
        check("reset_count", bus.instr_count, 32'd0);
        reset_dut();

        foreach (vecs[i]) begin
            bus.Op = vecs[i].op;
            bus.Funct = vecs[i].fn;
            bus.mem_ack = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_outputs", i), 32'(obs), 32'(vecs[i].exp));
            check($sformatf("vec%0d_count", i), bus.instr_count, vecs[i].cnt);
            @(posedge clk);
            #1;
        end

        // lw with three wait cycles in MEM_READ: 8 cycles total
        reset_dut();
        bus.Op = 6'b100011;
        rd_cycles = 0;
        done_cycle = 0;
        m2r_at_done = 1'b0;
        for (int k = 1; k <= 20 && done_cycle == 0; k++) begin
            bus.mem_ack = !(k >= 4 && k <= 6);
            @(negedge clk);
            if (bus.MemRead && bus.IorD) rd_cycles++;
            if (bus.instr_done) begin
                done_cycle = k;
                m2r_at_done = bus.MemtoReg;
            end
            @(posedge clk);
            #1;
        end
        check("lw_wait_latency", done_cycle, 32'd8);
        check("lw_read_cycles", rd_cycles, 32'd4);
        check("lw_memtoreg", 32'(m2r_at_done), 32'd1);
        check("lw_count", bus.instr_count, 32'd1);

        // Timeout: no ack for 16 FETCH cycles -> FAULT, sticky
        reset_dut();
        bus.mem_ack = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1 || k == 16) check($sformatf("to_fetch_c%0d", k), 32'(obs), 32'(e_fetch_wait));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("to_fault_entry", 32'(obs), 32'(e_fault));
        bus.mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("to_fault_sticky", 32'(obs), 32'(e_fault));

        // Ack exactly in cycle 16 wins over the timeout
        reset_dut();
        bus.Op = 6'b000000;
        bus.Funct = 6'b100000;
        for (int k = 1; k <= 16; k++) begin
            bus.mem_ack = (k == 16);
            @(negedge clk);
            if (k == 16) check("ack16_fetch", 32'(obs), 32'(e_fetch));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("ack16_decode", 32'(obs), 32'(e_dec));

        // Reset dropped mid-MEM_WRITE after one retired add
        reset_dut();
        bus.mem_ack = 1'b1;
        bus.Op = 6'b000000;
        bus.Funct = 6'b100000;
        repeat (4) @(posedge clk);
        #1;
        bus.Op = 6'b101011;
        repeat (3) @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("mw_wait_outputs", 32'(obs), 32'(e_mwr_wait));
        check("mw_count_before", bus.instr_count, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mw_abort_outputs", 32'(obs), 32'(0));
        check("mw_abort_count", bus.instr_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mw_restart_fetch", 32'(obs), 32'(e_fetch_wait));
        check("mw_restart_count", bus.instr_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
